// File: rtl/ref_window_buf.sv
// Rotating-bank reference window buffer: writes one column per bank, reads the other banks as a
// horizontal search-window row. Optional next_block pulse enabled by REFBUF_NEXT_BLOCK_EN.
module ref_window_buf #(
  parameter int unsigned PIX_W           = 8,
  parameter int unsigned WORD_PIX        = 8,
  parameter int unsigned NUM_BANKS       = 4,
  parameter int unsigned DEPTH           = 23,
  parameter int unsigned BLOCKS_PER_LINE = 482,
  parameter int unsigned OUT_PIX         = (NUM_BANKS - 1) * WORD_PIX - 1,
  parameter int unsigned NEXT_BLK_ROW    = 8
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        flush_i,
  input  logic                        in_valid_i,
  output logic                        in_ready_o,
  input  logic [WORD_PIX*PIX_W-1:0]   ref_in_i,
  output logic                        win_valid_o,
  input  logic                        win_ready_i,
  output logic [OUT_PIX*PIX_W-1:0]    win_out_o,
  output logic [$clog2(DEPTH)-1:0]    win_row_o,
  output logic                        next_block_o,
  output logic                        line_done_o
);

  localparam int unsigned WordW = WORD_PIX * PIX_W;
  localparam int unsigned FullW = (NUM_BANKS - 1) * WordW;
  localparam int unsigned OutW  = OUT_PIX * PIX_W;
  localparam int unsigned RowW  = $clog2(DEPTH);
  localparam int unsigned ColW  = $clog2(BLOCKS_PER_LINE);
  localparam int unsigned WbW   = $clog2(NUM_BANKS);

  typedef enum logic [1:0] {StFill, StRun, StLend} state_e;

  state_e              state_q, state_d;
  logic [RowW-1:0]     row_q, row_d;
  logic [WbW-1:0]      wb_q, wb_d;
  logic [ColW-1:0]     col_q, col_d;
  logic                win_valid_q, win_valid_d;
  logic [OutW-1:0]     win_q, win_d;
  logic [RowW-1:0]     win_row_q, win_row_d;

  logic                accept;
  logic                row_last;
  logic [FullW-1:0]    rd_full;

  logic [WordW-1:0]    mem_q [NUM_BANKS][DEPTH];

  // Bank holding the k-th column after the write bank, oldest first.
  function automatic logic [WbW-1:0] rot(input logic [WbW-1:0] base, input int unsigned k);
    int unsigned s;
    s = 32'(base) + k;
    if (s >= NUM_BANKS) s = s - NUM_BANKS;
    return WbW'(s);
  endfunction

  assign in_ready_o = (state_q != StLend) && (!win_valid_q || win_ready_i);
  // A flush drops any beat presented in the same cycle.
  assign accept     = in_valid_i && in_ready_o && !flush_i;
  assign row_last   = (row_q == RowW'(DEPTH - 1));

  always_ff @(posedge clk_i) begin
    if (accept) begin
      mem_q[wb_q][row_q] <= ref_in_i;
    end
  end

  always_comb begin
    rd_full = '0;
    for (int unsigned k = 1; k < NUM_BANKS; k++) begin
      rd_full[(NUM_BANKS - 1 - k)*WordW +: WordW] = mem_q[rot(wb_q, k)][row_q];
    end
  end

  always_comb begin
    state_d     = state_q;
    row_d       = row_q;
    wb_d        = wb_q;
    col_d       = col_q;
    win_valid_d = win_valid_q;
    win_d       = win_q;
    win_row_d   = win_row_q;

    if (win_valid_q && win_ready_i) begin
      win_valid_d = 1'b0;
    end

    unique case (state_q)
      StFill, StRun: begin
        if (accept) begin
          if (state_q == StRun) begin
            win_valid_d = 1'b1;
            win_d       = OutW'(rd_full >> (FullW - OutW));
            win_row_d   = row_q;
          end
          if (row_last) begin
            row_d = '0;
            wb_d  = (wb_q == WbW'(NUM_BANKS - 1)) ? '0 : wb_q + 1'b1;
            col_d = col_q + 1'b1;
            if ((state_q == StFill) && (col_q == ColW'(NUM_BANKS - 2))) begin
              state_d = StRun;
            end
            if ((state_q == StRun) && (col_q == ColW'(BLOCKS_PER_LINE - 1))) begin
              state_d = StLend;
              col_d   = col_q;
            end
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      StLend: begin
        state_d = StFill;
        row_d   = '0;
        wb_d    = '0;
        col_d   = '0;
      end
      default: begin
        state_d = StFill;
      end
    endcase

    if (flush_i) begin
      state_d     = StFill;
      row_d       = '0;
      wb_d        = '0;
      col_d       = '0;
      win_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StFill;
      row_q       <= '0;
      wb_q        <= '0;
      col_q       <= '0;
      win_valid_q <= 1'b0;
      win_q       <= '0;
      win_row_q   <= '0;
    end else begin
      state_q     <= state_d;
      row_q       <= row_d;
      wb_q        <= wb_d;
      col_q       <= col_d;
      win_valid_q <= win_valid_d;
      win_q       <= win_d;
      win_row_q   <= win_row_d;
    end
  end

`ifdef REFBUF_NEXT_BLOCK_EN
  logic nb_q, nb_d;

  always_comb begin
    nb_d = accept && (state_q == StRun) && (row_q == RowW'(NEXT_BLK_ROW));
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      nb_q <= 1'b0;
    end else begin
      nb_q <= nb_d;
    end
  end

  assign next_block_o = nb_q;
`else
  assign next_block_o = 1'b0;
`endif

  assign line_done_o = (state_q == StLend);
  assign win_valid_o = win_valid_q;
  assign win_out_o   = win_q;
  assign win_row_o   = win_row_q;

endmodule

// File: tb/tb_ref_window_buf.sv
// Scoreboard bench for ref_window_buf: driver pushes expected window rows, negedge monitor checks.
module tb_ref_window_buf;

  localparam int unsigned WordW = 64;
  localparam int unsigned OutW  = 184;

  logic              clk = 1'b0;
  logic              rst, flush, in_valid, in_ready, win_valid, win_ready;
  logic              next_block, line_done;
  logic [WordW-1:0]  ref_in;
  logic [OutW-1:0]   win_out;
  logic [4:0]        win_row;

  always #5 clk = ~clk;

  ref_window_buf #(
    .PIX_W          (8),
    .WORD_PIX       (8),
    .NUM_BANKS      (4),
    .DEPTH          (23),
    .BLOCKS_PER_LINE(5),
    .OUT_PIX        (23),
    .NEXT_BLK_ROW   (8)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .ref_in_i    (ref_in),
    .win_valid_o (win_valid),
    .win_ready_i (win_ready),
    .win_out_o   (win_out),
    .win_row_o   (win_row),
    .next_block_o(next_block),
    .line_done_o (line_done)
  );

  typedef struct {
    logic [OutW-1:0] win;
    logic [4:0]      row;
    int              cyc;
  } exp_t;

  exp_t q[$];
  int   total = 0, bad = 0, cyc = 0, acc_cnt = 0;
  int   ld_cnt = 0, nb_cnt = 0, win_cnt = 0;
  bit   mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WordW-1:0] wd(input int c, input int r, input int ln);
    return {8'(192 + c), 8'(r), 8'(ln), 8'h5A, 8'(c * 7 + r), 8'(r + 1), 8'(c + ln * 3),
            8'(60 ^ r)};
  endfunction

  // Oldest column first; the last pixel of the newest column falls off.
  function automatic logic [OutW-1:0] expwin(input int c, input int r, input int ln);
    logic [191:0] f;
    f = {wd(c - 3, r, ln), wd(c - 2, r, ln), wd(c - 1, r, ln)};
    return f[191:8];
  endfunction

  task automatic chk(input string nm, input logic [191:0] act, input logic [191:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, req);
    end
  endtask

  task automatic send(input int c, input int r, input int ln, input bit gap);
    bit   acc;
    exp_t e;
    acc = 1'b0;
    if (gap) begin
      in_valid = 1'b0;
      repeat ($urandom_range(0, 1)) begin
        @(posedge clk);
        #1;
      end
    end
    in_valid = 1'b1;
    ref_in   = wd(c, r, ln);
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    if (!acc) begin
      total++;
      bad++;
      $display("FAIL beat_timeout: col %0d row %0d not accepted within 50 cycles", c, r);
    end else begin
      acc_cnt++;
      if (c >= 3) begin
        e.win = expwin(c, r, ln);
        e.row = 5'(r);
        e.cyc = cyc;
        q.push_back(e);
      end
    end
  endtask

  task automatic send_line(input int ln, input bit gap);
    for (int i = 0; i < 115; i++) send(i / 23, i % 23, ln, gap);
  endtask

  bit              prev_stall = 1'b0;
  logic [OutW-1:0] held_w;
  logic [4:0]      held_r;

  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (win_valid && win_ready) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL spurious_window: row %0d presented, none expected", win_row);
        end else begin
          e = q.pop_front();
          chk("win_out", 192'(win_out), 192'(e.win));
          chk("win_row", 192'(win_row), 192'(e.row));
          if (!prev_stall) chk("latency", 192'(cyc - e.cyc), 192'(0));
          win_cnt++;
        end
      end
      if (win_valid && !win_ready) begin
        chk("stall_in_ready", 192'(in_ready), 192'(0));
        if (prev_stall) begin
          chk("stall_hold_out", 192'(win_out), 192'(held_w));
          chk("stall_hold_row", 192'(win_row), 192'(held_r));
        end
        held_w     = win_out;
        held_r     = win_row;
        prev_stall = 1'b1;
      end else begin
        prev_stall = 1'b0;
      end
      if (line_done) begin
        ld_cnt++;
        chk("ld_in_ready", 192'(in_ready), 192'(0));
        chk("ld_last_row", 192'({win_valid, win_row}), 192'({1'b1, 5'd22}));
      end
      if (next_block) begin
        nb_cnt++;
`ifdef REFBUF_NEXT_BLOCK_EN
        chk("nb_row", 192'({win_valid, win_row}), 192'({1'b1, 5'd8}));
`endif
      end
    end
  end

  initial begin
    rst       = 1'b1;
    flush     = 1'b0;
    in_valid  = 1'b0;
    ref_in    = '0;
    win_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_in_ready", 192'(in_ready), 192'(1));
    chk("rst_win_valid", 192'(win_valid), 192'(0));
    chk("rst_win_out", 192'(win_out), 192'(0));
    chk("rst_win_row", 192'(win_row), 192'(0));
    chk("rst_next_block", 192'(next_block), 192'(0));
    chk("rst_line_done", 192'(line_done), 192'(0));
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    send_line(0, 1'b0);

    // Back-pressure mid-column of the second line.
    fork
      send_line(1, 1'b0);
      begin
        for (int k = 0; k < 3000; k++) begin
          if (acc_cnt >= 195) break;
          @(posedge clk);
          #1;
        end
        win_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 win_ready = 1'b1;
      end
    join

    send_line(2, 1'b1);

    // Flush at col 3 row 10 with a beat presented.
    for (int i = 0; i < 79; i++) send(i / 23, i % 23, 3, 1'b0);
    in_valid = 1'b1;
    flush    = 1'b1;
    ref_in   = wd(3, 10, 3);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_win_valid", 192'(win_valid), 192'(0));
    chk("flush_line_done", 192'(line_done), 192'(0));
    @(posedge clk);
    #1;

    send_line(4, 1'b0);

    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("queue_empty", 192'(q.size()), 192'(0));
    chk("window_count", 192'(win_cnt), 192'(194));
    chk("line_done_count", 192'(ld_cnt), 192'(4));
`ifdef REFBUF_NEXT_BLOCK_EN
    chk("next_block_count", 192'(nb_cnt), 192'(9));
`else
    chk("next_block_count", 192'(nb_cnt), 192'(0));
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
